// File: rtl/taxi_pcie_us_cq_reg_cpl_if.sv
// AXI4-Stream bundle shared by the PCIe CQ/CC ports; the source drives everything except tready.
interface taxi_axis_if #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = DATA_W / 32,
  parameter int USER_W = 1
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport snk (input tdata, tkeep, tvalid, tlast, tuser, output tready);
  modport mon (input tdata, tkeep, tvalid, tready, tlast, tuser);
endinterface

// File: rtl/taxi_pcie_us_cq_reg_cpl.sv
// UltraScale PCIe completer: single-DW CQ memory requests become 32-bit register accesses,
// and every non-posted request gets one CC completion (SC, UR or CA).
module taxi_pcie_us_cq_reg_cpl #(
  parameter int REG_ADDR_W = 16,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  taxi_axis_if.snk              s_axis_cq,
  taxi_axis_if.src              m_axis_cc,
  output logic [REG_ADDR_W-3:0] reg_addr,
  output logic [31:0]           reg_wr_data,
  output logic [3:0]            reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_ack,
  output logic                  reg_rd_en,
  input  logic [31:0]           reg_rd_data,
  input  logic                  reg_rd_ack,
  input  logic [15:0]           completer_id,
  input  logic                  completer_id_en,
  output logic                  stat_err_cor,
  output logic                  stat_err_uncor
);

  localparam int DATA_W = s_axis_cq.DATA_W;
  localparam int KEEP_W = m_axis_cc.KEEP_W;
  localparam int CNT_W  = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

  if (DATA_W != 128 && DATA_W != 256) begin : g_bad_width
    $error("taxi_pcie_us_cq_reg_cpl: DATA_W must be 128 or 256");
  end
  if (m_axis_cc.DATA_W != DATA_W || KEEP_W != DATA_W / 32) begin : g_bad_cc
    $error("taxi_pcie_us_cq_reg_cpl: CC interface must match CQ width with KEEP_W = DATA_W/32");
  end

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_DATA = 3'd1;
  localparam logic [2:0] ST_REG_WR  = 3'd2;
  localparam logic [2:0] ST_REG_RD  = 3'd3;
  localparam logic [2:0] ST_CPL     = 3'd4;
  localparam logic [2:0] ST_DROP    = 3'd5;

  localparam logic [3:0] REQ_MRD     = 4'b0000;
  localparam logic [3:0] REQ_MWR     = 4'b0001;
  localparam logic [3:0] REQ_IORD    = 4'b0010;
  localparam logic [3:0] REQ_IOWR    = 4'b0011;
  localparam logic [3:0] REQ_LOCK_RD = 4'b0111;
  localparam logic [3:0] REQ_CFG0_RD = 4'b1000;
  localparam logic [3:0] REQ_CFG1_RD = 4'b1001;
  localparam logic [3:0] REQ_CFG0_WR = 4'b1010;
  localparam logic [3:0] REQ_CFG1_WR = 4'b1011;

  localparam logic [2:0] CPL_SC = 3'd0;
  localparam logic [2:0] CPL_UR = 3'd1;
  localparam logic [2:0] CPL_CA = 3'd4;

  logic [2:0]            state_reg, state_next;
  logic                  tready_reg;
  logic [REG_ADDR_W-3:0] addr_reg;
  logic [4:0]            lo_addr_reg;
  logic [1:0]            at_reg;
  logic [3:0]            first_be_reg;
  logic [15:0]           req_id_reg;
  logic [7:0]            tag_reg;
  logic [2:0]            tc_reg;
  logic [2:0]            attr_reg;
  logic [31:0]           wr_data_reg;
  logic [31:0]           rd_data_reg;
  logic [2:0]            status_reg;
  logic [CNT_W-1:0]      rd_cnt;
  logic                  stat_cor_reg;
  logic                  stat_uncor_reg;

  logic        cq_fire;
  logic [3:0]  cq_req_type;
  logic [10:0] cq_dw_count;
  logic        cq_is_mwr1, cq_is_mrd1, cq_supported, cq_non_posted;
  logic [31:0] beat_wr_data;
  logic        rd_timeout;

  assign cq_fire       = s_axis_cq.tvalid && tready_reg;
  assign cq_req_type   = s_axis_cq.tdata[78:75];
  assign cq_dw_count   = s_axis_cq.tdata[74:64];
  assign cq_is_mwr1    = (cq_req_type == REQ_MWR) && (cq_dw_count == 11'd1);
  assign cq_is_mrd1    = (cq_req_type == REQ_MRD) && (cq_dw_count == 11'd1);
  assign cq_supported  = cq_is_mwr1 || cq_is_mrd1;
  assign cq_non_posted = cq_req_type inside {REQ_MRD, REQ_IORD, REQ_IOWR, REQ_LOCK_RD,
                                             REQ_CFG0_RD, REQ_CFG1_RD, REQ_CFG0_WR, REQ_CFG1_WR};
  assign rd_timeout    = (rd_cnt == CNT_W'(RD_TIMEOUT - 1));

  // At 256 bits the single write DW rides in the descriptor beat; at 128 it follows in beat 1.
  if (DATA_W == 256) begin : g_dw_256
    assign beat_wr_data = s_axis_cq.tdata[159:128];
  end else begin : g_dw_128
    assign beat_wr_data = 32'd0;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cq_fire) begin
          if (cq_is_mwr1) begin
            if (DATA_W == 256) begin
              state_next = s_axis_cq.tlast ? ST_REG_WR : ST_DROP;
            end else begin
              state_next = ST_WR_DATA;
            end
          end else if (cq_is_mrd1) begin
            state_next = s_axis_cq.tlast ? ST_REG_RD : ST_DROP;
          end else if (cq_non_posted) begin
            state_next = ST_CPL;
          end else begin
            state_next = s_axis_cq.tlast ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_WR_DATA: if (cq_fire) state_next = s_axis_cq.tlast ? ST_REG_WR : ST_DROP;
      ST_DROP:    if (cq_fire && s_axis_cq.tlast) state_next = ST_IDLE;
      ST_REG_WR:  if (reg_wr_ack) state_next = ST_IDLE;
      ST_REG_RD:  if (reg_rd_ack || rd_timeout) state_next = ST_CPL;
      ST_CPL:     if (m_axis_cc.tready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      tready_reg     <= 1'b0;
      addr_reg       <= '0;
      lo_addr_reg    <= '0;
      at_reg         <= '0;
      first_be_reg   <= '0;
      req_id_reg     <= '0;
      tag_reg        <= '0;
      tc_reg         <= '0;
      attr_reg       <= '0;
      wr_data_reg    <= '0;
      rd_data_reg    <= '0;
      status_reg     <= CPL_SC;
      rd_cnt         <= '0;
      stat_cor_reg   <= 1'b0;
      stat_uncor_reg <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= only; the blocking next-state math lives in always_comb.
      state_reg      <= state_next;
      tready_reg     <= (state_next == ST_IDLE) || (state_next == ST_WR_DATA) || (state_next == ST_DROP);
      stat_cor_reg   <= 1'b0;
      stat_uncor_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (cq_fire) begin
            addr_reg       <= s_axis_cq.tdata[REG_ADDR_W-1:2];
            lo_addr_reg    <= s_axis_cq.tdata[6:2];
            at_reg         <= s_axis_cq.tdata[1:0];
            first_be_reg   <= s_axis_cq.tuser[3:0];
            req_id_reg     <= s_axis_cq.tdata[95:80];
            tag_reg        <= s_axis_cq.tdata[103:96];
            tc_reg         <= s_axis_cq.tdata[123:121];
            attr_reg       <= s_axis_cq.tdata[126:124];
            wr_data_reg    <= beat_wr_data;
            rd_data_reg    <= '0;
            rd_cnt         <= '0;
            status_reg     <= cq_supported ? CPL_SC : CPL_UR;
            stat_uncor_reg <= !cq_supported;
          end
        end
        ST_WR_DATA: begin
          if (cq_fire) wr_data_reg <= s_axis_cq.tdata[31:0];
        end
        ST_REG_RD: begin
          // A late ack that lands on the timeout cycle still completes successfully.
          if (reg_rd_ack) begin
            rd_data_reg <= reg_rd_data;
            status_reg  <= CPL_SC;
          end else if (rd_timeout) begin
            rd_data_reg  <= '0;
            status_reg   <= CPL_CA;
            stat_cor_reg <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [1:0]   be_lo_idx, be_hi_idx;
  logic [12:0]  byte_cnt;
  logic [127:0] cpl_desc;
  logic         cc_active;

  always_comb begin
    be_lo_idx = 2'd0;
    be_hi_idx = 2'd0;
    casez (first_be_reg)
      4'b???1: be_lo_idx = 2'd0;
      4'b??10: be_lo_idx = 2'd1;
      4'b?100: be_lo_idx = 2'd2;
      4'b1000: be_lo_idx = 2'd3;
      default: be_lo_idx = 2'd0;
    endcase
    casez (first_be_reg)
      4'b1???: be_hi_idx = 2'd3;
      4'b01??: be_hi_idx = 2'd2;
      4'b001?: be_hi_idx = 2'd1;
      default: be_hi_idx = 2'd0;
    endcase
    byte_cnt = (first_be_reg == 4'd0) ? 13'd1 : (13'(be_hi_idx) - 13'(be_lo_idx) + 13'd1);
  end

  always_comb begin
    cpl_desc          = '0;
    cpl_desc[6:0]     = {lo_addr_reg, be_lo_idx};
    cpl_desc[9:8]     = at_reg;
    cpl_desc[28:16]   = byte_cnt;
    cpl_desc[42:32]   = (status_reg == CPL_SC) ? 11'd1 : 11'd0;
    cpl_desc[45:43]   = status_reg;
    cpl_desc[63:48]   = req_id_reg;
    cpl_desc[71:64]   = tag_reg;
    cpl_desc[87:72]   = completer_id;
    cpl_desc[88]      = completer_id_en;
    cpl_desc[91:89]   = tc_reg;
    cpl_desc[94:92]   = attr_reg;
    cpl_desc[127:96]  = rd_data_reg;
  end

  assign cc_active        = (state_reg == ST_CPL);
  assign m_axis_cc.tvalid = cc_active;
  assign m_axis_cc.tlast  = cc_active;
  assign m_axis_cc.tuser  = '0;
  assign m_axis_cc.tdata  = cc_active ? DATA_W'(cpl_desc) : '0;
  assign m_axis_cc.tkeep  = !cc_active ? '0 :
                            (status_reg == CPL_SC) ? KEEP_W'(4'b1111) : KEEP_W'(4'b0111);

  assign s_axis_cq.tready = tready_reg;
  assign reg_addr         = addr_reg;
  assign reg_wr_data      = wr_data_reg;
  assign reg_wr_strb      = first_be_reg;
  assign reg_wr_en        = (state_reg == ST_REG_WR);
  assign reg_rd_en        = (state_reg == ST_REG_RD);
  assign stat_err_cor     = stat_cor_reg;
  assign stat_err_uncor   = stat_uncor_reg;

  // Descriptor bits, keep and sideband fields this completer never looks at.
  logic unused_cq;
  assign unused_cq = ^{s_axis_cq.tkeep, s_axis_cq.tuser, s_axis_cq.tdata};

endmodule

// File: tb/tb_taxi_pcie_us_cq_reg_cpl.sv
// Directed bench: table of single-DW requests with hand-computed results, plus drop,
// backpressure and mid-completion reset sequences.
module tb_taxi_pcie_us_cq_reg_cpl;

  localparam int DATA_W     = 256;
  localparam int KEEP_W     = DATA_W / 32;
  localparam int REG_ADDR_W = 16;
  localparam int RD_TIMEOUT = 16;
  localparam int WINDOW     = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(88)) cq_if ();
  taxi_axis_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(33)) cc_if ();

  logic [REG_ADDR_W-3:0] reg_addr;
  logic [31:0]           reg_wr_data;
  logic [3:0]            reg_wr_strb;
  logic                  reg_wr_en, reg_wr_ack;
  logic                  reg_rd_en, reg_rd_ack;
  logic [31:0]           reg_rd_data;
  logic                  stat_err_cor, stat_err_uncor;
  logic [15:0]           completer_id = 16'hBEEF;
  logic                  completer_id_en = 1'b1;

  taxi_pcie_us_cq_reg_cpl #(.REG_ADDR_W(REG_ADDR_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_cq(cq_if), .m_axis_cc(cc_if),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_ack(reg_wr_ack),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .reg_rd_ack(reg_rd_ack),
    .completer_id(completer_id), .completer_id_en(completer_id_en),
    .stat_err_cor(stat_err_cor), .stat_err_uncor(stat_err_uncor)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req_type;
    logic [10:0] dw;
    logic [63:0] addr;
    logic [3:0]  be;
    logic [7:0]  tag;
    logic [15:0] req_id;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_delay;
    logic        exp_wr;
    logic        exp_rd;
    logic [13:0] exp_reg_addr;
    logic        exp_cpl;
    logic [6:0]  exp_lo;
    logic [12:0] exp_bc;
    logic [10:0] exp_dwc;
    logic [2:0]  exp_st;
    logic [7:0]  exp_keep;
    logic [31:0] exp_data;
    logic        exp_uncor;
    logic        exp_cor;
    int          exp_rd_cycles;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [255:0] cq_beat(input vec_t v);
    logic [255:0] b;
    b = '0;
    b[63:2]    = v.addr[63:2];
    b[1:0]     = v.tag[1:0];
    b[74:64]   = v.dw;
    b[78:75]   = v.req_type;
    b[95:80]   = v.req_id;
    b[103:96]  = v.tag;
    b[123:121] = v.tc;
    b[126:124] = v.attr;
    b[159:128] = v.wdata;
    return b;
  endfunction

  // Presents one beat from a negedge; returns at the negedge after the handshake edge.
  task automatic send_beat(input logic [255:0] data, input logic [3:0] be, input logic last,
                           output logic ok);
    ok = 1'b0;
    cq_if.tdata     = data;
    cq_if.tuser     = '0;
    cq_if.tuser[3:0] = be;
    cq_if.tlast     = last;
    cq_if.tvalid    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (cq_if.tready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cq_if.tvalid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic ok;
    logic seen_wr;
    int   rd_cycles, cpl_n, uncor_n, cor_n;
    logic [255:0] d;
    seen_wr = 1'b0; rd_cycles = 0; cpl_n = 0; uncor_n = 0; cor_n = 0;
    send_beat(cq_beat(v), v.be, 1'b1, ok);
    check($sformatf("v%0d accept", idx), ok, 1'b1);
    for (int c = 0; c < WINDOW; c++) begin
      reg_wr_ack = 1'b0;
      reg_rd_ack = 1'b0;
      if (stat_err_uncor) uncor_n++;
      if (stat_err_cor) cor_n++;
      if (reg_wr_en) begin
        if (!seen_wr) begin
          check($sformatf("v%0d wr_addr", idx), reg_addr, v.exp_reg_addr);
          check($sformatf("v%0d wr_strb", idx), reg_wr_strb, v.be);
          check($sformatf("v%0d wr_data", idx), reg_wr_data, v.wdata);
        end
        seen_wr = 1'b1;
        reg_wr_ack = 1'b1;
      end
      if (reg_rd_en) begin
        if (rd_cycles == 0) check($sformatf("v%0d rd_addr", idx), reg_addr, v.exp_reg_addr);
        rd_cycles++;
        if (rd_cycles > v.ack_delay) begin
          reg_rd_ack  = 1'b1;
          reg_rd_data = v.rdata;
        end
      end
      if (cc_if.tvalid) begin
        cpl_n++;
        if (cpl_n == 1) begin
          d = cc_if.tdata;
          check($sformatf("v%0d lower_addr", idx), d[6:0], v.exp_lo);
          check($sformatf("v%0d addr_type", idx), d[9:8], v.tag[1:0]);
          check($sformatf("v%0d byte_count", idx), d[28:16], v.exp_bc);
          check($sformatf("v%0d dword_count", idx), d[42:32], v.exp_dwc);
          check($sformatf("v%0d status", idx), d[45:43], v.exp_st);
          check($sformatf("v%0d req_id", idx), d[63:48], v.req_id);
          check($sformatf("v%0d tag", idx), d[71:64], v.tag);
          check($sformatf("v%0d cpl_id", idx), d[88:72], {1'b1, 16'hBEEF});
          check($sformatf("v%0d tc_attr", idx), d[94:89], {v.attr, v.tc});
          check($sformatf("v%0d data", idx), d[127:96], v.exp_data);
          check($sformatf("v%0d upper_zero", idx), d[255:128], 128'd0);
          check($sformatf("v%0d tkeep", idx), cc_if.tkeep, v.exp_keep);
          check($sformatf("v%0d tlast", idx), cc_if.tlast, 1'b1);
        end
      end
      @(negedge clk);
    end
    reg_wr_ack = 1'b0;
    reg_rd_ack = 1'b0;
    check($sformatf("v%0d wr_seen", idx), seen_wr, v.exp_wr);
    check($sformatf("v%0d rd_seen", idx), rd_cycles != 0, v.exp_rd);
    check($sformatf("v%0d cpl_beats", idx), cpl_n, v.exp_cpl ? 1 : 0);
    check($sformatf("v%0d uncor_pulses", idx), uncor_n, v.exp_uncor ? 1 : 0);
    check($sformatf("v%0d cor_pulses", idx), cor_n, v.exp_cor ? 1 : 0);
    if (v.exp_rd_cycles != 0) check($sformatf("v%0d rd_cycles", idx), rd_cycles, v.exp_rd_cycles);
    check($sformatf("v%0d cq_tready_idle", idx), cq_if.tready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic stable;
    int   uncor_n, wr_n, cc_n;
    logic [255:0] cap;
    vec_t s;

    cq_if.tvalid = 1'b0; cq_if.tdata = '0; cq_if.tuser = '0; cq_if.tlast = 1'b0; cq_if.tkeep = '1;
    cc_if.tready = 1'b1;
    reg_wr_ack = 1'b0; reg_rd_ack = 1'b0; reg_rd_data = '0;

    repeat (3) @(negedge clk);
    check("rst cq_tready", cq_if.tready, 1'b0);
    check("rst cc_tvalid", cc_if.tvalid, 1'b0);
    check("rst cc_tdata", cc_if.tdata, '0);
    check("rst cc_tkeep", cc_if.tkeep, '0);
    check("rst reg_en", {reg_wr_en, reg_rd_en}, 2'b00);
    check("rst reg_outs", {reg_addr, reg_wr_data, reg_wr_strb}, '0);
    check("rst stats", {stat_err_cor, stat_err_uncor}, 2'b00);
    rst_n = 1'b1;

    // type dw addr be tag req_id tc attr wdata rdata delay | wr rd reg_addr cpl lo bc dwc st keep data uncor cor rd_cycles
    vecs[0]  = '{4'h1, 11'd1, 64'h1008, 4'hF, 8'h01, 16'h0100, 3'd0, 3'd0, 32'hDEADBEEF, 32'h0, 0,
                 1'b1, 1'b0, 14'h0402, 1'b0, 7'h00, 13'd0, 11'd0, 3'd0, 8'h00, 32'h0, 1'b0, 1'b0, 0};
    vecs[1]  = '{4'h0, 11'd1, 64'h2004, 4'h6, 8'h2A, 16'h0100, 3'd2, 3'd1, 32'h0, 32'h12345678, 3,
                 1'b0, 1'b1, 14'h0801, 1'b1, 7'h05, 13'd2, 11'd1, 3'd0, 8'h0F, 32'h12345678, 1'b0, 1'b0, 4};
    vecs[2]  = '{4'h0, 11'd1, 64'h0040, 4'hF, 8'h11, 16'h0A0B, 3'd7, 3'd5, 32'h0, 32'hFFFFFFFF, 1000,
                 1'b0, 1'b1, 14'h0010, 1'b1, 7'h40, 13'd4, 11'd0, 3'd4, 8'h07, 32'h0, 1'b0, 1'b1, 16};
    vecs[3]  = '{4'h0, 11'd4, 64'h0100, 4'hF, 8'h33, 16'h0C0D, 3'd1, 3'd2, 32'h0, 32'h0, 0,
                 1'b0, 1'b0, 14'h0000, 1'b1, 7'h00, 13'd4, 11'd0, 3'd1, 8'h07, 32'h0, 1'b1, 1'b0, 0};
    vecs[4]  = '{4'h0, 11'd1, 64'h007C, 4'h8, 8'hFF, 16'hFFFF, 3'd3, 3'd4, 32'h0, 32'hA5A50001, 0,
                 1'b0, 1'b1, 14'h001F, 1'b1, 7'h7F, 13'd1, 11'd1, 3'd0, 8'h0F, 32'hA5A50001, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'h0, 11'd1, 64'h0008, 4'h0, 8'h01, 16'h0001, 3'd0, 3'd0, 32'h0, 32'hCAFEF00D, 1,
                 1'b0, 1'b1, 14'h0002, 1'b1, 7'h08, 13'd1, 11'd1, 3'd0, 8'h0F, 32'hCAFEF00D, 1'b0, 1'b0, 2};
    vecs[6]  = '{4'h1, 11'd1, 64'hFFFC, 4'h3, 8'h02, 16'h0100, 3'd0, 3'd0, 32'h0000BEEF, 32'h0, 0,
                 1'b1, 1'b0, 14'h3FFF, 1'b0, 7'h00, 13'd0, 11'd0, 3'd0, 8'h00, 32'h0, 1'b0, 1'b0, 0};
    vecs[7]  = '{4'h0, 11'd1, 64'h0010, 4'h9, 8'h7E, 16'h2222, 3'd5, 3'd3, 32'h0, 32'h0BADF00D, 2,
                 1'b0, 1'b1, 14'h0004, 1'b1, 7'h10, 13'd4, 11'd1, 3'd0, 8'h0F, 32'h0BADF00D, 1'b0, 1'b0, 3};
    vecs[8]  = '{4'h2, 11'd1, 64'h0000, 4'h1, 8'h44, 16'h3333, 3'd0, 3'd0, 32'h0, 32'h0, 0,
                 1'b0, 1'b0, 14'h0000, 1'b1, 7'h00, 13'd1, 11'd0, 3'd1, 8'h07, 32'h0, 1'b1, 1'b0, 0};
    vecs[9]  = '{4'hC, 11'd1, 64'h0000, 4'hF, 8'h45, 16'h3333, 3'd0, 3'd0, 32'h0, 32'h0, 0,
                 1'b0, 1'b0, 14'h0000, 1'b0, 7'h00, 13'd0, 11'd0, 3'd0, 8'h00, 32'h0, 1'b1, 1'b0, 0};
    vecs[10] = '{4'h1, 11'd1, 64'h20004, 4'hF, 8'h03, 16'h0100, 3'd0, 3'd0, 32'h11223344, 32'h0, 0,
                 1'b1, 1'b0, 14'h0001, 1'b0, 7'h00, 13'd0, 11'd0, 3'd0, 8'h00, 32'h0, 1'b0, 1'b0, 0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Two-beat MWr with dword_count=2: dropped, no register access, no completion.
    s = vecs[0];
    s.dw = 11'd2;
    s.addr = 64'h3000;
    uncor_n = 0; wr_n = 0; cc_n = 0;
    send_beat(cq_beat(s), 4'hF, 1'b0, ok);
    check("drop beat0 accept", ok, 1'b1);
    if (stat_err_uncor) uncor_n++;
    check("drop tready mid", cq_if.tready, 1'b1);
    send_beat({224'h0, 32'h55AA55AA}, 4'hF, 1'b1, ok);
    check("drop beat1 accept", ok, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (stat_err_uncor) uncor_n++;
      if (reg_wr_en || reg_rd_en) wr_n++;
      if (cc_if.tvalid) cc_n++;
      @(negedge clk);
    end
    check("drop uncor_pulses", uncor_n, 1);
    check("drop reg_access", wr_n, 0);
    check("drop cpl_beats", cc_n, 0);
    check("drop tready after", cq_if.tready, 1'b1);

    // Completion held off by CC backpressure, then abandoned by reset.
    s = vecs[1];
    s.tag = 8'h5C;
    s.req_id = 16'h1234;
    s.rdata = 32'h600DCAFE;
    cc_if.tready = 1'b0;
    send_beat(cq_beat(s), s.be, 1'b1, ok);
    check("stall accept", ok, 1'b1);
    stable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      reg_rd_ack = 1'b0;
      if (cc_if.tvalid) begin
        stable = 1'b1;
        break;
      end
      if (reg_rd_en) begin
        reg_rd_ack = 1'b1;
        reg_rd_data = s.rdata;
      end
      @(negedge clk);
    end
    reg_rd_ack = 1'b0;
    check("stall tvalid seen", stable, 1'b1);
    cap = cc_if.tdata;
    cq_if.tdata = cq_beat(vecs[4]);
    cq_if.tuser = '0;
    cq_if.tlast = 1'b1;
    cq_if.tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!cc_if.tvalid || cc_if.tdata !== cap || cq_if.tready) stable = 1'b0;
    end
    check("stall stable", stable, 1'b1);
    check("stall data", cap[127:96], 32'h600DCAFE);
    check("stall tag", cap[71:64], 8'h5C);
    rst_n = 1'b0;
    @(negedge clk);
    check("stall rst tvalid", cc_if.tvalid, 1'b0);
    check("stall rst cq_tready", cq_if.tready, 1'b0);
    cq_if.tvalid = 1'b0;
    cc_if.tready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(99, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_pcie_us_cq_reg_cpl.md
Name: taxi_pcie_us_cq_reg_cpl

Overview:
- PCIe UltraScale completer-side block. It receives memory read and write requests on the CQ stream and turns each into one 32-bit access on a simple register port.
- For every non-posted request it returns a completion on the CC stream.
- It is the responder counterpart to the requester-side DMA interface, and lets host software reach device control registers behind a BAR.
- Only single-DW requests are supported. Anything else is rejected with a UR completion or dropped.

Parameters:
- REG_ADDR_W, 16: register port byte-address width; the port carries address bits [REG_ADDR_W-1:2].
- RD_TIMEOUT, 1024: cycles to wait for reg_rd_ack before returning completion status CA.
- s_axis_cq and m_axis_cc DATA_W is taken from the interface. It must be 128 or 256, checked at elaboration. KEEP_W = DATA_W/32.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_axis_cq  taxi_axis_if.snk  DATA_W  CQ requests (UltraScale descriptor in tdata[127:0], first_be in tuser[3:0]).
- m_axis_cc  taxi_axis_if.src  DATA_W  CC completions.
- reg_addr  out  REG_ADDR_W-2  DW address.
- reg_wr_data  out  32  write data.
- reg_wr_strb  out  4  byte enables (first_be).
- reg_wr_en  out  1  write request; held until reg_wr_ack.
- reg_wr_ack  in  1  write accepted.
- reg_rd_en  out  1  read request; held until reg_rd_ack or timeout.
- reg_rd_data  in  32  read data, valid with reg_rd_ack.
- reg_rd_ack  in  1  read done.
- completer_id  in  16  placed in CC descriptor.
- completer_id_en  in  1  CC completer-ID-enable bit.
- stat_err_cor  out  1  one-cycle pulse on read timeout.
- stat_err_uncor  out  1  one-cycle pulse on unsupported or malformed request.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. s_axis_cq.tready, m_axis_cc.tvalid, reg_wr_en, reg_rd_en and both stat outputs go to 0; all other outputs go to 0.
- Reset mid-operation abandons the access; no completion is produced.
- States: IDLE, WR_DATA, REG_WR, REG_RD, CPL, DROP.
- IDLE:
  - tready=1. Latch the descriptor on the first beat: address [63:2], dword_count [74:64], req_type [78:75], requester_id [95:80], tag [103:96], TC [123:121], attr [126:124], first_be.
  - MWr with dword_count=1: at DATA_W=256, data is tdata[159:128] of beat 0 and the block goes to REG_WR; it goes to DROP instead if tlast=0. At DATA_W=128, go to WR_DATA.
  - MRd with dword_count=1: go to REG_RD if tlast=1, else DROP.
  - Any other req_type or dword_count!=1: pulse stat_err_uncor.
    - If non-posted (MRd, IORd, IOWr, locked, Cfg): build a UR completion and go to CPL.
    - Posted: discard the request (DROP if tlast=0, else stay in IDLE).
- WR_DATA: tready=1; take tdata[31:0] as write data. If tlast=1, go to REG_WR; otherwise go to DROP.
- DROP: tready=1 until a beat with tlast=1, then back to IDLE.
- REG_WR: reg_wr_en=1, reg_addr = address[REG_ADDR_W-1:2], reg_wr_strb = first_be. On reg_wr_ack, go to IDLE; no completion is sent.
- REG_RD: reg_rd_en=1 and a counter runs.
  - reg_rd_ack: capture the data, status SC, go to CPL.
  - Counter reaches RD_TIMEOUT-1 with no ack: status CA, data 0, pulse stat_err_cor, go to CPL.
  - An ack in the same cycle as the timeout wins (SC).
- CPL: one beat. tvalid=1, tlast=1, tuser=0.
  - tdata[6:0] = lower address = {address[6:2], lowest set bit index of first_be}; index 0 if first_be=0.
  - tdata[9:8] = addr type.
  - tdata[28:16] = byte count = span from first to last set bit of first_be, 1 if first_be=0.
  - tdata[42:32] = 1 for SC; 0 for UR/CA.
  - tdata[45:43] = status (SC=0, UR=1, CA=4).
  - tdata[63:48] = requester_id, [71:64] = tag, [87:72] = completer_id, [88] = completer_id_en, [91:89] = TC, [94:92] = attr.
  - tdata[127:96] = read data.
  - tkeep = 4'b1111 for SC and 4'b0111 for UR/CA, upper bits 0.
  - Hold the beat until tready, then go to IDLE.
- tready is 0 outside IDLE, WR_DATA and DROP, so only one request is in flight at a time.
- Throughput: write is 2 cycles plus ack latency. Read latency from the CQ beat to CC tvalid is ack latency plus 2 cycles.

Test Plan:
- MWr, addr 0x1008, first_be=0xF, data 0xDEADBEEF -> reg_wr_en with reg_addr=0x402, strb=0xF, data 0xDEADBEEF; no CC beat.
- MRd, addr 0x2004, first_be=0x6, tag 0x2A, ack after 3 cycles with 0x12345678 -> one CC beat: lower addr 0x05, byte count 2, dword_count 1, status 0, tag 0x2A, data 0x12345678, tkeep 0xF.
- MRd with no ack, RD_TIMEOUT=16 -> after 16 cycles: stat_err_cor pulse, CC status 4, dword_count 0, tkeep 0x7.
- MRd dword_count=4 -> stat_err_uncor pulse, UR completion (status 1) with matching tag; the next request proceeds normally.
- MWr dword_count=2 spanning 2 beats -> dropped, stat_err_uncor pulse, no reg access; tready returns to 1 after tlast.
- m_axis_cc.tready held low for 10 cycles during a completion -> tvalid and tdata stay stable and the CQ is stalled; assert rst_n=0 mid-stall -> tvalid=0 the next cycle.
